// File: rtl/aurora_rx_frame_buffer.sv
// aurora_rx_frame_buffer
// Store-and-forward RX frame buffer for the Aurora 64B/66B user-clock side.
// Frames are written speculatively and committed on a good CRC; bad,
// oversize or overflowing frames are rolled back whole. Committed words are
// replayed through a 2-entry prefetch/skid stage on an AXI-stream master.
// Optional feature macro: AURORA_RX_FRAME_STATS_EN (frame statistics counters).
module aurora_rx_frame_buffer #(
  parameter int ADDR_WIDTH      = 9,
  parameter int MAX_FRAME_WORDS = 256
) (
  input  logic        sysClk,
  input  logic        resetN,
  input  logic [31:0] sAxisTdata,
  input  logic [3:0]  sAxisTkeep,
  input  logic [7:0]  sAxisTuser,
  input  logic        sAxisTlast,
  input  logic        sAxisTvalid,
  output logic [31:0] mAxisTdata,
  output logic [3:0]  mAxisTkeep,
  output logic        mAxisTlast,
  output logic        mAxisTvalid,
  input  logic        mAxisTready,
  output logic [15:0] goodFrames,
  output logic [15:0] crcErrFrames,
  output logic [15:0] dropFrames,
  output logic        bufEmpty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int BCW   = $clog2(MAX_FRAME_WORDS + 1);
  localparam logic [ADDR_WIDTH:0] FULL_DIST = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [BCW-1:0]      MAX_BEATS = BCW'(MAX_FRAME_WORDS);

  logic [36:0]         mem [DEPTH];
  logic [ADDR_WIDTH:0] wrCommit, wrSpec, rdPtr;
  logic                dropping;
  logic [BCW-1:0]      beatCnt;

  logic full, beatOk, acceptBeat, frameDrop, crcOk;
  logic unusedTuser;

  assign full        = (wrSpec - rdPtr) == FULL_DIST;
  assign beatOk      = beatCnt < MAX_BEATS;
  assign acceptBeat  = sAxisTvalid && !dropping && !full && beatOk;
  // the overflow beat itself marks the frame as dropped
  assign frameDrop   = dropping || !acceptBeat;
  assign crcOk       = sAxisTuser[1] && sAxisTuser[0];
  assign unusedTuser = ^sAxisTuser[7:2];

  // buffer RAM write at the speculative pointer
  always_ff @(posedge sysClk) begin
    if (acceptBeat) mem[wrSpec[ADDR_WIDTH-1:0]] <= {sAxisTlast, sAxisTkeep, sAxisTdata};
  end

  // speculative write, commit and rollback of frames
  always_ff @(posedge sysClk or negedge resetN) begin
    if (!resetN) begin
      wrSpec   <= '0;
      wrCommit <= '0;
      dropping <= 1'b0;
      beatCnt  <= '0;
    end else if (sAxisTvalid) begin
      if (acceptBeat) wrSpec <= wrSpec + 1'b1;
      else            dropping <= 1'b1;
      if (beatOk) beatCnt <= beatCnt + 1'b1;
      if (sAxisTlast) begin
        dropping <= 1'b0;
        beatCnt  <= '0;
        if (frameDrop)  wrSpec   <= wrCommit;
        else if (crcOk) wrCommit <= wrSpec + 1'b1;
        else            wrSpec   <= wrCommit;
      end
    end
  end

  logic [36:0] ramQ, outWord, skidWord;
  logic        ramVld, outValid, skidValid, pop, rdIssue;
  logic [1:0]  stageCnt;

  assign pop      = outValid && mAxisTready;
  assign stageCnt = {1'b0, outValid} + {1'b0, skidValid} + {1'b0, ramVld};
  // issue only when the word is guaranteed a slot in the 2-entry stage
  assign rdIssue  = (rdPtr != wrCommit) && ((stageCnt - {1'b0, pop}) <= 2'd1);

  // synchronous RAM read port
  always_ff @(posedge sysClk) begin
    if (rdIssue) ramQ <= mem[rdPtr[ADDR_WIDTH-1:0]];
  end

  // read pointer and RAM-data-valid tracking
  always_ff @(posedge sysClk or negedge resetN) begin
    if (!resetN) begin
      rdPtr  <= '0;
      ramVld <= 1'b0;
    end else begin
      ramVld <= rdIssue;
      if (rdIssue) rdPtr <= rdPtr + 1'b1;
    end
  end

  // 2-entry prefetch/skid output stage
  always_ff @(posedge sysClk or negedge resetN) begin
    if (!resetN) begin
      outValid  <= 1'b0;
      outWord   <= '0;
      skidValid <= 1'b0;
      skidWord  <= '0;
    end else if (!outValid || pop) begin
      if (skidValid) begin
        outWord   <= skidWord;
        outValid  <= 1'b1;
        skidValid <= ramVld;
        if (ramVld) skidWord <= ramQ;
      end else if (ramVld) begin
        outWord  <= ramQ;
        outValid <= 1'b1;
      end else begin
        outValid <= 1'b0;
      end
    end else if (ramVld) begin
      skidWord  <= ramQ;
      skidValid <= 1'b1;
    end
  end

  assign mAxisTvalid = outValid;
  assign mAxisTlast  = outWord[36];
  assign mAxisTkeep  = outWord[35:32];
  assign mAxisTdata  = outWord[31:0];
  assign bufEmpty    = (rdPtr == wrCommit) && !ramVld && !outValid && !skidValid;

`ifdef AURORA_RX_FRAME_STATS_EN
  logic        evGood, evCrc, evDrop;
  logic [15:0] goodCnt, crcCnt, dropCnt;

  assign evGood = sAxisTvalid && sAxisTlast && !frameDrop && crcOk;
  assign evCrc  = sAxisTvalid && sAxisTlast && !frameDrop && !crcOk;
  assign evDrop = sAxisTvalid && sAxisTlast && frameDrop;

  // saturating frame statistics
  always_ff @(posedge sysClk or negedge resetN) begin
    if (!resetN) begin
      goodCnt <= '0;
      crcCnt  <= '0;
      dropCnt <= '0;
    end else begin
      if (evGood && goodCnt != 16'hFFFF) goodCnt <= goodCnt + 1'b1;
      if (evCrc  && crcCnt  != 16'hFFFF) crcCnt  <= crcCnt  + 1'b1;
      if (evDrop && dropCnt != 16'hFFFF) dropCnt <= dropCnt + 1'b1;
    end
  end

  assign goodFrames   = goodCnt;
  assign crcErrFrames = crcCnt;
  assign dropFrames   = dropCnt;
`else
  assign goodFrames   = 16'h0000;
  assign crcErrFrames = 16'h0000;
  assign dropFrames   = 16'h0000;
`endif

endmodule
